// File: rtl/d_fifo_reader_pkg.sv
// ---------------------------------------------------------------------------
// d_fifo_reader_pkg
// Shared definitions for the D0/D1 FIFO reader: FSM state encodings, class
// codes, burst counter width and a saturating increment helper.
// ---------------------------------------------------------------------------
package d_fifo_reader_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACTIVE = 2'b01,
        PAUSED = 2'b10
    } state_e;

    localparam logic CLASS_D0 = 1'b0;
    localparam logic CLASS_D1 = 1'b1;

    localparam int BURST_W = 4;

    // Increment v by one, holding at max_v once reached.
    function automatic logic [BURST_W-1:0] sat_inc(input logic [BURST_W-1:0] v,
                                                   input logic [BURST_W-1:0] max_v);
        logic [BURST_W-1:0] r;
        if (v >= max_v) begin
            r = max_v;
        end else begin
            r = v + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/d_fifo_reader_arbiter.sv
// ---------------------------------------------------------------------------
// d_burst_arbiter
// D0-priority arbiter with a burst cap: after MAX_BURST consecutive D0 pops
// while D1 holds data, one D1 pop is forced.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   init          0 = synchronous clear of the burst counter
//   en            a pop is allowed this cycle
//   empty_d0/d1   FIFO empty flags
//   grant         one-hot grant, bit 0 = D0, bit 1 = D1 (combinational)
// ---------------------------------------------------------------------------
module d_burst_arbiter
    import d_fifo_reader_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       init,
    input  logic       en,
    input  logic       empty_d0,
    input  logic       empty_d1,
    output logic [1:0] grant
);

    localparam logic [BURST_W-1:0] MAX_B = BURST_W'(MAX_BURST);

    logic [BURST_W-1:0] burst_cnt_q;
    logic [BURST_W-1:0] burst_cnt_d;
    logic [1:0]         grant_s;

    // Grant selection: D1 when D0 is empty or the D0 burst cap is reached.
    always_comb begin
        grant_s = 2'b00;
        if (en) begin
            if (empty_d0) begin
                if (!empty_d1) begin
                    grant_s = 2'b10;
                end else begin
                    grant_s = 2'b00;
                end
            end else if ((burst_cnt_q == MAX_B) && !empty_d1) begin
                grant_s = 2'b10;
            end else begin
                grant_s = 2'b01;
            end
        end else begin
            grant_s = 2'b00;
        end
    end

    // Burst counter next value: only D0 pops made while D1 waits are counted.
    always_comb begin
        burst_cnt_d = burst_cnt_q;
        if (empty_d1) begin
            burst_cnt_d = 4'd0;
        end else if (grant_s[1]) begin
            burst_cnt_d = 4'd0;
        end else if (grant_s[0]) begin
            burst_cnt_d = sat_inc(burst_cnt_q, MAX_B);
        end else begin
            burst_cnt_d = burst_cnt_q;
        end
    end

    // Burst counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_cnt_q <= 4'd0;
        end else if (!init) begin
            burst_cnt_q <= 4'd0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign grant = grant_s;

endmodule

// File: rtl/d_fifo_reader.sv
// ---------------------------------------------------------------------------
// d_fifo_reader
// Consumer of the D0/D1 class FIFOs. Issues combinational pops, tracks
// IDLE/ACTIVE/PAUSED, and realigns the one-cycle-late FIFO data into a
// registered {valid, class, data} stream (pop in N -> output in N+2).
// Build option: define POP_COUNT_EN to build the 8-bit pop counters;
// otherwise pop_cnt_D0/pop_cnt_D1 read 8'd0.
// Ports:
//   clk, reset_L              clock, asynchronous active-low reset
//   init                      0 = synchronous clear, 1 = run
//   empty_D0/D1, error_D0/D1  FIFO status flags
//   data_D0/D1                FIFO data_out (valid the cycle after a pop)
//   pause                     downstream almost-full, blocks new pops
//   rd_enable_D0/D1           pop strobes (combinational)
//   valid_out/class_out/data_out  registered output beat
//   error_out                 sticky FIFO error
//   pop_cnt_D0/D1             pop counters
// ---------------------------------------------------------------------------
module d_fifo_reader
    import d_fifo_reader_pkg::*;
#(
    parameter int data_width = 6,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  init,
    input  logic                  empty_D0,
    input  logic                  empty_D1,
    input  logic                  error_D0,
    input  logic                  error_D1,
    input  logic [data_width-1:0] data_D0,
    input  logic [data_width-1:0] data_D1,
    input  logic                  pause,
    output logic                  rd_enable_D0,
    output logic                  rd_enable_D1,
    output logic                  valid_out,
    output logic                  class_out,
    output logic [data_width-1:0] data_out,
    output logic                  error_out,
    output logic [7:0]            pop_cnt_D0,
    output logic [7:0]            pop_cnt_D1
);

    state_e                state_q;
    state_e                state_d;
    logic                  any_s;
    logic                  pop_en_s;
    logic [1:0]            grant_s;

    logic                  tag_valid_q;
    logic                  tag_valid_d;
    logic                  tag_class_q;
    logic                  tag_class_d;
    logic                  valid_out_q;
    logic                  valid_out_d;
    logic                  class_out_q;
    logic                  class_out_d;
    logic [data_width-1:0] data_out_q;
    logic [data_width-1:0] data_out_d;
    logic                  error_q;
    logic                  error_d;

    assign any_s = !empty_D0 || !empty_D1;

    // Next-state logic for the pop FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (any_s && !pause) begin
                    state_d = ACTIVE;
                end else begin
                    state_d = IDLE;
                end
            end
            ACTIVE: begin
                if (pause) begin
                    state_d = PAUSED;
                end else if (!any_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = ACTIVE;
                end
            end
            PAUSED: begin
                if (!pause && any_s) begin
                    state_d = ACTIVE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A pop happens whenever the FSM is (or is about to be) ACTIVE; this covers
    // both steady streaming and the same-cycle IDLE/PAUSED -> ACTIVE restart.
    // Reset and init mask it so no word is consumed while clearing.
    assign pop_en_s = reset_L && init && (state_d == ACTIVE);

    d_burst_arbiter #(
        .MAX_BURST (MAX_BURST)
    ) u_arb (
        .clk      (clk),
        .rst_n    (reset_L),
        .init     (init),
        .en       (pop_en_s),
        .empty_d0 (empty_D0),
        .empty_d1 (empty_D1),
        .grant    (grant_s)
    );

    assign rd_enable_D0 = grant_s[0];
    assign rd_enable_D1 = grant_s[1];

    // Tag pipe and output stage: the tag captured at the pop selects which
    // FIFO data_out to register one cycle later.
    always_comb begin
        tag_valid_d = grant_s[0] || grant_s[1];
        tag_class_d = grant_s[1] ? CLASS_D1 : CLASS_D0;
        valid_out_d = tag_valid_q;
        if (tag_valid_q) begin
            class_out_d = tag_class_q;
            data_out_d  = (tag_class_q == CLASS_D1) ? data_D1 : data_D0;
        end else begin
            class_out_d = CLASS_D0;
            data_out_d  = '0;
        end
        error_d = error_q || error_D0 || error_D1;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= IDLE;
        end else if (!init) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Tag pipe, output beat and sticky error registers.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            tag_valid_q <= 1'b0;
            tag_class_q <= 1'b0;
            valid_out_q <= 1'b0;
            class_out_q <= 1'b0;
            data_out_q  <= '0;
            error_q     <= 1'b0;
        end else if (!init) begin
            tag_valid_q <= 1'b0;
            tag_class_q <= 1'b0;
            valid_out_q <= 1'b0;
            class_out_q <= 1'b0;
            data_out_q  <= '0;
            error_q     <= 1'b0;
        end else begin
            tag_valid_q <= tag_valid_d;
            tag_class_q <= tag_class_d;
            valid_out_q <= valid_out_d;
            class_out_q <= class_out_d;
            data_out_q  <= data_out_d;
            error_q     <= error_d;
        end
    end

    assign valid_out = valid_out_q;
    assign class_out = class_out_q;
    assign data_out  = data_out_q;
    assign error_out = error_q;

`ifdef POP_COUNT_EN
    logic [7:0] pop_cnt_d0_q;
    logic [7:0] pop_cnt_d0_d;
    logic [7:0] pop_cnt_d1_q;
    logic [7:0] pop_cnt_d1_d;

    // Pop counters wrap naturally at 8 bits.
    always_comb begin
        if (grant_s[0]) begin
            pop_cnt_d0_d = pop_cnt_d0_q + 8'd1;
        end else begin
            pop_cnt_d0_d = pop_cnt_d0_q;
        end
        if (grant_s[1]) begin
            pop_cnt_d1_d = pop_cnt_d1_q + 8'd1;
        end else begin
            pop_cnt_d1_d = pop_cnt_d1_q;
        end
    end

    // Pop counter registers.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            pop_cnt_d0_q <= 8'd0;
            pop_cnt_d1_q <= 8'd0;
        end else if (!init) begin
            pop_cnt_d0_q <= 8'd0;
            pop_cnt_d1_q <= 8'd0;
        end else begin
            pop_cnt_d0_q <= pop_cnt_d0_d;
            pop_cnt_d1_q <= pop_cnt_d1_d;
        end
    end

    assign pop_cnt_D0 = pop_cnt_d0_q;
    assign pop_cnt_D1 = pop_cnt_d1_q;
`else
    assign pop_cnt_D0 = 8'd0;
    assign pop_cnt_D1 = 8'd0;
`endif

endmodule
